id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter EXC_RI, default 5'd10, exception code raised for an undecodable instruction.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; asserted (0) forces every register to its reset value immediately, independent of clk.
REQ-004 stall  input  1  load-use hazard hold; when 1 a bubble is inserted into the EX-side register (IF side holds upstream).
REQ-005 clr  input  1  flush (exception/eret); clears the EX-side register.
REQ-006 code_ID, PC_ID  input  32 each  instruction word and its PC from fetch.
REQ-007 Exc_ID  input  [6:2]  fetch exception code; BD_ID  input  1  branch-delay flag.
REQ-008 wbEn  input  1; wbAddr  input  5; wbData  input  32  register-file write port from writeback.
REQ-009 fwdEn_EX/fwdAddr_EX/fwdData_EX and fwdEn_MEM/fwdAddr_MEM/fwdData_MEM  input  1/5/32  forwarding sources.
REQ-010 instr  output  WIDTH_INSTR  decoded instruction enum of code_ID (shared decoder), combinational, to fetch.
REQ-011 cmp  output  1; imm16  output  16; jmpAddr  output  26; jmpReg  output  32  branch/jump operands to fetch, combinational.
REQ-012 code_EX, PC_EX, rsData_EX, rtData_EX  output  32 each; Exc_EX  output  [6:2]; BD_EX  output  1  registered ID/EX stage.

Function
REQ-013 Register file SHALL hold 32 x 32-bit GPRs; GPR0 SHALL read 0 always and SHALL never be written.
REQ-014 On rising clk with wbEn=1 and wbAddr!=0, GPR[wbAddr] SHALL take wbData.
REQ-015 rs = code_ID[25:21], rt = code_ID[20:16]; each operand SHALL resolve with priority: addr 0 -> 0; fwdEn_EX && match -> fwdData_EX; fwdEn_MEM && match -> fwdData_MEM; wbEn && wbAddr match -> wbData (same-cycle bypass); else GPR.
REQ-016 cmp SHALL be: BEQ rs==rt; BNE rs!=rt; BLEZ rs<=0; BGTZ rs>0; BLTZ rs<0; BGEZ rs>=0 (signed 32-bit, forwarded operands); 0 for all other instructions.
REQ-017 imm16 = code_ID[15:0]; jmpAddr = code_ID[25:0]; jmpReg = resolved rs value.
REQ-018 Exception select: Exc_ID!=0 -> Exc_ID passes unchanged; else instruction decodes to none and code_ID!=0 -> EXC_RI; else 0. code_ID=0 (nop/bubble) SHALL never raise EXC_RI.
REQ-019 ID/EX update per rising edge, priority: clr -> all outputs 0; else stall -> code_EX, rsData_EX, rtData_EX, Exc_EX = 0 while PC_EX <= PC_ID and BD_EX <= BD_ID (bubble keeps PC/BD for EPC); else all fields capture current values.
REQ-020 clr and stall both 1 -> clr wins (all zero).
REQ-021 Combinational outputs (REQ-010..011) SHALL be valid in the same cycle as code_ID, no added latency; ID/EX latency exactly 1 cycle.

Reset
REQ-022 reset=0 SHALL asynchronously clear all 32 GPRs and all ID/EX outputs to 0.
REQ-023 reset asserted mid-operation (including with wbEn=1 in that cycle) SHALL discard the write; deassertion SHALL take effect at the next rising edge with no spurious write.

Verification
REQ-024 Write GPR5=0x1234 via WB, next cycle code_ID=ADDU using rs=5, no forwards -> rsData_EX=0x00001234 one cycle later.
REQ-025 Same cycle: wbEn=1, wbAddr=8, wbData=0xAAAA0000 and code_ID BEQ rs=8, rt=8, GPR8 old=0 -> cmp=1, jmpReg=0xAAAA0000.
REQ-026 rs=9 matched by fwd EX (0x1) and MEM (0x2) simultaneously, BGTZ -> resolved rs=0x1, cmp=1; fwdData_EX=0xFFFFFFFF -> cmp=0, BLTZ cmp=1.
REQ-027 wbAddr=0, wbData=0xDEADBEEF, then read rs=0 -> 0; code_ID=0xFC000000 (undefined opcode), Exc_ID=0 -> Exc_EX=10; Exc_ID=4 -> Exc_EX=4.
REQ-028 stall=1 with PC_ID=0x00003010, BD_ID=1 -> code_EX=0, Exc_EX=0, PC_EX=0x00003010, BD_EX=1; stall=1 and clr=1 -> PC_EX=0, BD_EX=0.
REQ-029 Load GPR1..31 nonzero, pulse reset=0 between clock edges -> all outputs 0 before next edge; all GPR reads 0 afterwards.

Source files
------------

// File: rtl/id_stage.sv
// Instruction-decode stage: GPR file with write-back bypass, operand
// forwarding, branch compare, exception select and the ID/EX pipeline register.
module id_stage #(
    parameter logic [4:0]  EXC_RI      = 5'd10,
    parameter int unsigned WIDTH_INSTR = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   clr,
    input  logic [31:0]            code_ID,
    input  logic [31:0]            PC_ID,
    input  logic [6:2]             Exc_ID,
    input  logic                   BD_ID,
    input  logic                   wbEn,
    input  logic [4:0]             wbAddr,
    input  logic [31:0]            wbData,
    input  logic                   fwdEn_EX,
    input  logic [4:0]             fwdAddr_EX,
    input  logic [31:0]            fwdData_EX,
    input  logic                   fwdEn_MEM,
    input  logic [4:0]             fwdAddr_MEM,
    input  logic [31:0]            fwdData_MEM,
    output logic [WIDTH_INSTR-1:0] instr,
    output logic                   cmp,
    output logic [15:0]            imm16,
    output logic [25:0]            jmpAddr,
    output logic [31:0]            jmpReg,
    output logic [31:0]            code_EX,
    output logic [31:0]            PC_EX,
    output logic [31:0]            rsData_EX,
    output logic [31:0]            rtData_EX,
    output logic [6:2]             Exc_EX,
    output logic                   BD_EX
);

    typedef enum logic [5:0] {
        I_NONE, I_SLL, I_SRL, I_SRA, I_SLLV, I_SRLV, I_SRAV, I_JR, I_JALR,
        I_SYSCALL, I_BREAK, I_MFHI, I_MTHI, I_MFLO, I_MTLO, I_MULT, I_MULTU,
        I_DIV, I_DIVU, I_ADD, I_ADDU, I_SUB, I_SUBU, I_AND, I_OR, I_XOR, I_NOR,
        I_SLT, I_SLTU, I_BLTZ, I_BGEZ, I_J, I_JAL, I_BEQ, I_BNE, I_BLEZ, I_BGTZ,
        I_ADDI, I_ADDIU, I_SLTI, I_SLTIU, I_ANDI, I_ORI, I_XORI, I_LUI,
        I_ERET, I_MFC0, I_MTC0, I_LB, I_LH, I_LW, I_LBU, I_LHU, I_SB, I_SH, I_SW
    } instr_e;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    instr_e      dec;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [4:0]  exc_sel;

    logic [31:0] gpr_q [32];
    logic [31:0] gpr_d [32];

    logic [31:0] code_ex_q, code_ex_d;
    logic [31:0] pc_ex_q, pc_ex_d;
    logic [31:0] rs_ex_q, rs_ex_d;
    logic [31:0] rt_ex_q, rt_ex_d;
    logic [4:0]  exc_ex_q, exc_ex_d;
    logic        bd_ex_q, bd_ex_d;

    assign opcode  = code_ID[31:26];
    assign funct   = code_ID[5:0];
    assign rs_addr = code_ID[25:21];
    assign rt_addr = code_ID[20:16];

    // Operand resolution: $0, then youngest forward, then same-cycle write-back, then GPR.
    function automatic logic [31:0] resolve(
        input logic [4:0]  a,
        input logic [31:0] gval,
        input logic        en_ex,
        input logic [4:0]  ad_ex,
        input logic [31:0] d_ex,
        input logic        en_mem,
        input logic [4:0]  ad_mem,
        input logic [31:0] d_mem,
        input logic        en_wb,
        input logic [4:0]  ad_wb,
        input logic [31:0] d_wb
    );
        if (a == 5'd0)                       return '0;
        else if (en_ex && (ad_ex == a))      return d_ex;
        else if (en_mem && (ad_mem == a))    return d_mem;
        else if (en_wb && (ad_wb == a))      return d_wb;
        else                                 return gval;
    endfunction

    // Shared instruction decoder.
    always_comb begin
        dec = I_NONE;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h00: dec = I_SLL;
                    6'h02: dec = I_SRL;
                    6'h03: dec = I_SRA;
                    6'h04: dec = I_SLLV;
                    6'h06: dec = I_SRLV;
                    6'h07: dec = I_SRAV;
                    6'h08: dec = I_JR;
                    6'h09: dec = I_JALR;
                    6'h0C: dec = I_SYSCALL;
                    6'h0D: dec = I_BREAK;
                    6'h10: dec = I_MFHI;
                    6'h11: dec = I_MTHI;
                    6'h12: dec = I_MFLO;
                    6'h13: dec = I_MTLO;
                    6'h18: dec = I_MULT;
                    6'h19: dec = I_MULTU;
                    6'h1A: dec = I_DIV;
                    6'h1B: dec = I_DIVU;
                    6'h20: dec = I_ADD;
                    6'h21: dec = I_ADDU;
                    6'h22: dec = I_SUB;
                    6'h23: dec = I_SUBU;
                    6'h24: dec = I_AND;
                    6'h25: dec = I_OR;
                    6'h26: dec = I_XOR;
                    6'h27: dec = I_NOR;
                    6'h2A: dec = I_SLT;
                    6'h2B: dec = I_SLTU;
                    default: dec = I_NONE;
                endcase
            end
            6'h01: begin
                if (rt_addr == 5'd0)      dec = I_BLTZ;
                else if (rt_addr == 5'd1) dec = I_BGEZ;
            end
            6'h02: dec = I_J;
            6'h03: dec = I_JAL;
            6'h04: dec = I_BEQ;
            6'h05: dec = I_BNE;
            6'h06: dec = I_BLEZ;
            6'h07: dec = I_BGTZ;
            6'h08: dec = I_ADDI;
            6'h09: dec = I_ADDIU;
            6'h0A: dec = I_SLTI;
            6'h0B: dec = I_SLTIU;
            6'h0C: dec = I_ANDI;
            6'h0D: dec = I_ORI;
            6'h0E: dec = I_XORI;
            6'h0F: dec = I_LUI;
            6'h10: begin
                if (code_ID == 32'h4200_0018) dec = I_ERET;
                else if (rs_addr == 5'd0)     dec = I_MFC0;
                else if (rs_addr == 5'd4)     dec = I_MTC0;
            end
            6'h20: dec = I_LB;
            6'h21: dec = I_LH;
            6'h23: dec = I_LW;
            6'h24: dec = I_LBU;
            6'h25: dec = I_LHU;
            6'h28: dec = I_SB;
            6'h29: dec = I_SH;
            6'h2B: dec = I_SW;
            default: dec = I_NONE;
        endcase
    end

    // Forwarded operands, branch compare and exception selection.
    always_comb begin
        rs_val = resolve(rs_addr, gpr_q[rs_addr], fwdEn_EX, fwdAddr_EX, fwdData_EX,
                         fwdEn_MEM, fwdAddr_MEM, fwdData_MEM, wbEn, wbAddr, wbData);
        rt_val = resolve(rt_addr, gpr_q[rt_addr], fwdEn_EX, fwdAddr_EX, fwdData_EX,
                         fwdEn_MEM, fwdAddr_MEM, fwdData_MEM, wbEn, wbAddr, wbData);
        case (dec)
            I_BEQ:   cmp = (rs_val == rt_val);
            I_BNE:   cmp = (rs_val != rt_val);
            I_BLEZ:  cmp = ($signed(rs_val) <= 0);
            I_BGTZ:  cmp = ($signed(rs_val) > 0);
            I_BLTZ:  cmp = ($signed(rs_val) < 0);
            I_BGEZ:  cmp = ($signed(rs_val) >= 0);
            default: cmp = 1'b0;
        endcase
        if (Exc_ID != 5'd0)                            exc_sel = Exc_ID;
        else if ((dec == I_NONE) && (code_ID != '0))   exc_sel = EXC_RI;
        else                                           exc_sel = '0;
    end

    assign instr   = WIDTH_INSTR'(dec);
    assign imm16   = code_ID[15:0];
    assign jmpAddr = code_ID[25:0];
    assign jmpReg  = rs_val;

    // GPR write port; $0 is never written.
    always_comb begin
        gpr_d = gpr_q;
        if (wbEn && (wbAddr != 5'd0)) gpr_d[wbAddr] = wbData;
    end

    // GPR storage with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) gpr_q <= '{default: '0};
        else        gpr_q <= gpr_d;
    end

    // ID/EX next state: flush beats bubble; a bubble keeps PC/BD so EPC stays correct.
    always_comb begin
        code_ex_d = code_ID;
        pc_ex_d   = PC_ID;
        rs_ex_d   = rs_val;
        rt_ex_d   = rt_val;
        exc_ex_d  = exc_sel;
        bd_ex_d   = BD_ID;
        if (clr) begin
            code_ex_d = '0;
            pc_ex_d   = '0;
            rs_ex_d   = '0;
            rt_ex_d   = '0;
            exc_ex_d  = '0;
            bd_ex_d   = 1'b0;
        end else if (stall) begin
            code_ex_d = '0;
            rs_ex_d   = '0;
            rt_ex_d   = '0;
            exc_ex_d  = '0;
        end
    end

    // ID/EX pipeline register with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            code_ex_q <= '0;
            pc_ex_q   <= '0;
            rs_ex_q   <= '0;
            rt_ex_q   <= '0;
            exc_ex_q  <= '0;
            bd_ex_q   <= 1'b0;
        end else begin
            code_ex_q <= code_ex_d;
            pc_ex_q   <= pc_ex_d;
            rs_ex_q   <= rs_ex_d;
            rt_ex_q   <= rt_ex_d;
            exc_ex_q  <= exc_ex_d;
            bd_ex_q   <= bd_ex_d;
        end
    end

    assign code_EX   = code_ex_q;
    assign PC_EX     = pc_ex_q;
    assign rsData_EX = rs_ex_q;
    assign rtData_EX = rt_ex_q;
    assign Exc_EX    = exc_ex_q;
    assign BD_EX     = bd_ex_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: expected ID/EX contents are queued when the
// inputs are driven and compared one clock later; combinational outputs are
// checked within the cycle.
module tb_id_stage;

    logic        clk;
    logic        reset;
    logic        stall, clr;
    logic [31:0] code_ID, PC_ID;
    logic [6:2]  Exc_ID;
    logic        BD_ID;
    logic        wbEn;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;
    logic        fwdEn_EX, fwdEn_MEM;
    logic [4:0]  fwdAddr_EX, fwdAddr_MEM;
    logic [31:0] fwdData_EX, fwdData_MEM;
    logic [5:0]  instr;
    logic        cmp;
    logic [15:0] imm16;
    logic [25:0] jmpAddr;
    logic [31:0] jmpReg;
    logic [31:0] code_EX, PC_EX, rsData_EX, rtData_EX;
    logic [6:2]  Exc_EX;
    logic        BD_EX;

    typedef struct packed {
        logic [31:0] code;
        logic [31:0] pc;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [4:0]  exc;
        logic        bd;
    } idex_t;

    idex_t sb_q[$];
    int    checks   = 0;
    int    failures = 0;

    id_stage #(.EXC_RI(5'd10), .WIDTH_INSTR(6)) dut (
        .clk(clk), .reset(reset), .stall(stall), .clr(clr),
        .code_ID(code_ID), .PC_ID(PC_ID), .Exc_ID(Exc_ID), .BD_ID(BD_ID),
        .wbEn(wbEn), .wbAddr(wbAddr), .wbData(wbData),
        .fwdEn_EX(fwdEn_EX), .fwdAddr_EX(fwdAddr_EX), .fwdData_EX(fwdData_EX),
        .fwdEn_MEM(fwdEn_MEM), .fwdAddr_MEM(fwdAddr_MEM), .fwdData_MEM(fwdData_MEM),
        .instr(instr), .cmp(cmp), .imm16(imm16), .jmpAddr(jmpAddr), .jmpReg(jmpReg),
        .code_EX(code_EX), .PC_EX(PC_EX), .rsData_EX(rsData_EX), .rtData_EX(rtData_EX),
        .Exc_EX(Exc_EX), .BD_EX(BD_EX)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_ex(input idex_t e);
        chk("code_EX",   code_EX,         e.code);
        chk("PC_EX",     PC_EX,           e.pc);
        chk("rsData_EX", rsData_EX,       e.rs);
        chk("rtData_EX", rtData_EX,       e.rt);
        chk("Exc_EX",    32'(Exc_EX),     32'(e.exc));
        chk("BD_EX",     32'(BD_EX),      32'(e.bd));
    endtask

    // Queue the expected ID/EX contents, clock once, then compare.
    task automatic step(input logic [31:0] code, input logic [31:0] pc,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input logic [4:0] exc, input logic bd);
        idex_t e;
        sb_q.push_back('{code: code, pc: pc, rs: rs, rt: rt, exc: exc, bd: bd});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk_ex(e);
        end
    endtask

    function automatic logic [31:0] gval(input int i);
        return 32'h5A00_0000 | 32'(i);
    endfunction

    initial begin
        logic [31:0] c;
        reset = 1'b0; stall = 1'b0; clr = 1'b0;
        code_ID = '0; PC_ID = '0; Exc_ID = '0; BD_ID = 1'b0;
        wbEn = 1'b0; wbAddr = '0; wbData = '0;
        fwdEn_EX = 1'b0; fwdAddr_EX = '0; fwdData_EX = '0;
        fwdEn_MEM = 1'b0; fwdAddr_MEM = '0; fwdData_MEM = '0;

        // Reset state
        #2;
        chk_ex('{code: '0, pc: '0, rs: '0, rt: '0, exc: '0, bd: 1'b0});
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Write GPR5, then read it through ADDU
        wbEn = 1'b1; wbAddr = 5'd5; wbData = 32'h0000_1234; code_ID = '0; PC_ID = 32'h100;
        step(32'h0, 32'h100, 32'h0, 32'h0, 5'd0, 1'b0);
        wbEn = 1'b0; code_ID = 32'h00A6_1821; PC_ID = 32'h104;
        #1;
        chk("addu_decoded", 32'(instr != 6'd0), 32'd1);
        chk("addu_cmp", 32'(cmp), 32'd0);
        step(32'h00A6_1821, 32'h104, 32'h0000_1234, 32'h0, 5'd0, 1'b0);

        // Same-cycle write-back bypass into BEQ
        wbEn = 1'b1; wbAddr = 5'd8; wbData = 32'hAAAA_0000;
        code_ID = 32'h1108_0004; PC_ID = 32'h108;
        #1;
        chk("beq_cmp", 32'(cmp), 32'd1);
        chk("beq_jmpReg", jmpReg, 32'hAAAA_0000);
        chk("beq_imm16", 32'(imm16), 32'h0000_0004);
        chk("beq_jmpAddr", 32'(jmpAddr), 32'h0108_0004);
        step(32'h1108_0004, 32'h108, 32'hAAAA_0000, 32'hAAAA_0000, 5'd0, 1'b0);

        // GPR8 now committed; BNE against $0
        wbEn = 1'b0; code_ID = 32'h1500_0000; PC_ID = 32'h10C;
        #1;
        chk("bne_cmp", 32'(cmp), 32'd1);
        step(32'h1500_0000, 32'h10C, 32'hAAAA_0000, 32'h0, 5'd0, 1'b0);

        // Forward priority and signed compares on rs=9
        code_ID = 32'h1D20_0000; PC_ID = 32'h110;
        fwdEn_EX = 1'b1; fwdAddr_EX = 5'd9; fwdData_EX = 32'h1;
        fwdEn_MEM = 1'b1; fwdAddr_MEM = 5'd9; fwdData_MEM = 32'h2;
        #1;
        chk("fwd_ex_prio", jmpReg, 32'h1);
        chk("bgtz_pos", 32'(cmp), 32'd1);
        fwdData_EX = 32'hFFFF_FFFF;
        #1;
        chk("bgtz_neg", 32'(cmp), 32'd0);
        code_ID = 32'h0520_0000;
        #1;
        chk("bltz_neg", 32'(cmp), 32'd1);
        code_ID = 32'h0521_0000;
        #1;
        chk("bgez_neg", 32'(cmp), 32'd0);
        code_ID = 32'h1920_0000;
        #1;
        chk("blez_neg", 32'(cmp), 32'd1);
        code_ID = 32'h1D20_0000; fwdEn_EX = 1'b0;
        #1;
        chk("fwd_mem", jmpReg, 32'h2);
        chk("bgtz_mem", 32'(cmp), 32'd1);
        step(32'h1D20_0000, 32'h110, 32'h2, 32'h0, 5'd0, 1'b0);
        fwdEn_MEM = 1'b0;

        // Writes to $0 are ignored
        wbEn = 1'b1; wbAddr = 5'd0; wbData = 32'hDEAD_BEEF;
        code_ID = 32'h0000_0021; PC_ID = 32'h114;
        #1;
        chk("r0_bypass", jmpReg, 32'h0);
        step(32'h0000_0021, 32'h114, 32'h0, 32'h0, 5'd0, 1'b0);
        wbEn = 1'b0; PC_ID = 32'h118;
        step(32'h0000_0021, 32'h118, 32'h0, 32'h0, 5'd0, 1'b0);

        // Exception select
        code_ID = 32'hFC00_0000; PC_ID = 32'h11C; Exc_ID = 5'd0;
        #1;
        chk("undef_instr", 32'(instr), 32'd0);
        step(32'hFC00_0000, 32'h11C, 32'h0, 32'h0, 5'd10, 1'b0);
        Exc_ID = 5'd4; PC_ID = 32'h120;
        step(32'hFC00_0000, 32'h120, 32'h0, 32'h0, 5'd4, 1'b0);
        Exc_ID = 5'd0; code_ID = '0; PC_ID = 32'h124;
        step(32'h0, 32'h124, 32'h0, 32'h0, 5'd0, 1'b0);

        // Stall bubble, stall+clr, clr alone, then normal capture
        stall = 1'b1; PC_ID = 32'h0000_3010; BD_ID = 1'b1;
        code_ID = 32'h00A6_1821; Exc_ID = 5'd4;
        step(32'h0, 32'h0000_3010, 32'h0, 32'h0, 5'd0, 1'b1);
        clr = 1'b1;
        step(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        stall = 1'b0;
        step(32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        clr = 1'b0; Exc_ID = 5'd0; PC_ID = 32'h3014;
        step(32'h00A6_1821, 32'h3014, 32'h0000_1234, 32'h0, 5'd0, 1'b1);
        BD_ID = 1'b0;

        // Fill GPR1..31
        for (int i = 1; i < 32; i++) begin
            wbEn = 1'b1; wbAddr = 5'(i); wbData = gval(i);
            code_ID = '0; PC_ID = 32'h200 + 32'(i * 4);
            step(32'h0, 32'h200 + 32'(i * 4), 32'h0, 32'h0, 5'd0, 1'b0);
        end
        wbEn = 1'b0;
        c = (32'd7 << 21) | (32'd31 << 16) | 32'h21;
        code_ID = c; PC_ID = 32'h400;
        step(c, 32'h400, gval(7), gval(31), 5'd0, 1'b0);

        // Asynchronous reset pulse between edges, with a write pending
        wbEn = 1'b1; wbAddr = 5'd3; wbData = 32'h0000_0077;
        #1;
        reset = 1'b0;
        #1;
        chk_ex('{code: '0, pc: '0, rs: '0, rt: '0, exc: '0, bd: 1'b0});
        chk("reset_jmpReg", jmpReg, 32'h0);
        wbEn = 1'b0;
        #1;
        reset = 1'b1;
        code_ID = '0; PC_ID = 32'h404;
        step(32'h0, 32'h404, 32'h0, 32'h0, 5'd0, 1'b0);

        // Every GPR reads zero after reset
        for (int i = 1; i < 32; i++) begin
            c = (32'(i) << 21) | (32'(i) << 16) | 32'h21;
            code_ID = c; PC_ID = 32'h500 + 32'(i * 4);
            #1;
            chk("gpr_cleared", jmpReg, 32'h0);
            step(c, 32'h500 + 32'(i * 4), 32'h0, 32'h0, 5'd0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
